// File: rtl/bus_xfer_arbiter.sv
// bus_xfer_arbiter: grants one register-to-register move at a time on the shared
// DATA bus and drives the one-hot per-register drive/capture strobes.
// Each transfer runs IDLE -> SETUP -> XFER; illegal transfers take IDLE -> ERR.
// Optional feature: define ARB_FIXED_PRIORITY_EN for fixed priority (lowest index
// wins, no round-robin pointer). Default build is round-robin.
module bus_xfer_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_REG = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] req_src,
    input  logic [NUM_REQ*IDX_W-1:0] req_dst,
    output logic [NUM_REQ-1:0]       done,
    output logic                     err,
    output logic [NUM_REG-1:0]       bus_enable,
    output logic [NUM_REG-1:0]       bus_latch,
    output logic                     busy
);

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REG-1:0] ONE_REG = NUM_REG'(1);
    localparam logic [NUM_REQ-1:0] ONE_REQ = NUM_REQ'(1);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StErr} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] done_d;
    logic               err_d;
    logic [NUM_REG-1:0] en_d, latch_d;

    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [31:0]        arb_idx;
    logic [IDX_W-1:0]   win_src, win_dst;
    logic               win_legal;

    // Arbitration: first requester at or after rr_ptr, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            arb_idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!win_valid && req[arb_idx]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(arb_idx);
            end
        end
        win_src   = req_src[32'(win_id)*IDX_W +: IDX_W];
        win_dst   = req_dst[32'(win_id)*IDX_W +: IDX_W];
        win_legal = (win_src != win_dst) && (32'(win_src) < NUM_REG) &&
                    (32'(win_dst) < NUM_REG);
    end

`ifdef ARB_FIXED_PRIORITY_EN
    assign rr_ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr_q;

    // Round-robin pointer moves past the requester just served (normal or illegal).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else if (state_q == StXfer || state_q == StErr) begin
            rr_ptr_q <= ID_W'((32'(id_q) + 1) % NUM_REQ);
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

    // Next state, holding registers and next registered output values.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        id_d    = id_q;
        en_d    = '0;
        latch_d = '0;
        done_d  = '0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    src_d = win_src;
                    dst_d = win_dst;
                    id_d  = win_id;
                    if (win_legal) begin
                        state_d = StSetup;
                        en_d    = ONE_REG << win_src;
                    end else begin
                        // Rejected: no strobes, completion and error next cycle.
                        state_d = StErr;
                        done_d  = ONE_REQ << win_id;
                        err_d   = 1'b1;
                    end
                end
            end
            StSetup: begin
                state_d = StXfer;
                en_d    = ONE_REG << src_q;
                latch_d = ONE_REG << dst_q;
                done_d  = ONE_REQ << id_q;
            end
            StXfer:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, holding registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            id_q       <= '0;
            bus_enable <= '0;
            bus_latch  <= '0;
            done       <= '0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            id_q       <= id_d;
            bus_enable <= en_d;
            bus_latch  <= latch_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Bench for bus_xfer_arbiter: directed scenarios plus random requesters, all checked
// against a transaction-level reference model and a bus-attached register file.
module tb_bus_xfer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NUM_REG = 8;
    localparam int IDX_W   = 3;
    localparam int BOUND   = 3 * NUM_REQ + 3;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*IDX_W-1:0] req_src = '0;
    logic [NUM_REQ*IDX_W-1:0] req_dst = '0;
    logic [NUM_REQ-1:0]       done;
    logic                     err;
    logic [NUM_REG-1:0]       bus_enable;
    logic [NUM_REG-1:0]       bus_latch;
    logic                     busy;

    bus_xfer_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_REG (NUM_REG),
        .IDX_W   (IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .done       (done),
        .err        (err),
        .bus_enable (bus_enable),
        .bus_latch  (bus_latch),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_REG-1:0] en;
        logic [NUM_REG-1:0] latch;
        logic [NUM_REQ-1:0] done;
        logic               err;
        logic               busy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_now;
    int          rr_m = 0;
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    logic [15:0] regs [NUM_REG];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int start);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [NUM_REG-1:0] v);
        for (int i = 0; i < NUM_REG; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Model: when free, one granted request expands into its whole output sequence.
    task automatic model_edge();
        exp_t e;
        int   w, s, d;
        if (!reset) begin
            exp_q.delete();
            rr_m    = 0;
            exp_now = '0;
            return;
        end
        if (exp_q.size() == 0) begin
            w = pick(req, rr_m);
            if (w >= 0) begin
                s = int'(req_src[w*IDX_W +: IDX_W]);
                d = int'(req_dst[w*IDX_W +: IDX_W]);
                e = '0;
                e.busy = 1'b1;
                if (s == d || s >= NUM_REG || d >= NUM_REG) begin
                    e.done[w] = 1'b1;
                    e.err     = 1'b1;
                    exp_q.push_back(e);
                end else begin
                    e.en[s] = 1'b1;
                    exp_q.push_back(e);
                    e.latch[d] = 1'b1;
                    e.done[w]  = 1'b1;
                    exp_q.push_back(e);
                end
                e = '0;
                exp_q.push_back(e);
`ifndef ARB_FIXED_PRIORITY_EN
                rr_m = (w + 1) % NUM_REQ;
`endif
            end
        end
        exp_now = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    endtask

    task automatic step();
        logic [NUM_REG-1:0] pe, pl;
        @(negedge clk);
        pe = bus_enable;
        pl = bus_latch;
        @(posedge clk);
        // Bus-attached register file: destination captures the driven source.
        if (pe != 0 && pl != 0) regs[idx_of(pl)] = regs[idx_of(pe)];
        model_edge();
        cycle++;
        #1;
        check_eq("bus_enable", 32'(bus_enable), 32'(exp_now.en));
        check_eq("bus_latch", 32'(bus_latch), 32'(exp_now.latch));
        check_eq("done", 32'(done), 32'(exp_now.done));
        check_eq("err", 32'(err), 32'(exp_now.err));
        check_eq("busy", 32'(busy), 32'(exp_now.busy));
        check_eq("inv_enable_onehot", 32'($onehot0(bus_enable)), 32'd1);
        check_eq("inv_latch_onehot", 32'($onehot0(bus_latch)), 32'd1);
        check_eq("inv_latch_needs_enable", 32'((bus_latch == 0) || (bus_enable != 0)), 32'd1);
    endtask

    task automatic set_slot(input int i, input int s, input int d);
        req_src[i*IDX_W +: IDX_W] = IDX_W'(s);
        req_dst[i*IDX_W +: IDX_W] = IDX_W'(d);
    endtask

    logic [15:0]        saved;
    int                 got_ord[$];
    int                 exp_ord[5];
    logic [NUM_REQ-1:0] active, drop, timed;
    int                 start_c [NUM_REQ];
    int                 rs, rd;

    initial begin
        for (int i = 0; i < NUM_REG; i++) regs[i] = 16'($urandom);
`ifdef ARB_FIXED_PRIORITY_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif

        // Reset held two cycles, released with no requests.
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("t1_busy_idle", 32'(busy), 32'd0);

        // Requester 1 moves R2 -> R5.
        saved = regs[2];
        set_slot(1, 2, 5);
        req = 4'b0010;
        step();
        check_eq("t2_setup_enable", 32'(bus_enable), 32'h04);
        step();
        check_eq("t2_xfer_enable", 32'(bus_enable), 32'h04);
        check_eq("t2_xfer_latch", 32'(bus_latch), 32'h20);
        check_eq("t2_xfer_done", 32'(done), 32'h2);
        req = '0;
        step();
        check_eq("t2_r5_value", 32'(regs[5]), 32'(saved));

        // Requester 3 asks for src == dst: rejected.
        set_slot(3, 4, 4);
        req = 4'b1000;
        step();
        check_eq("t4_done", 32'(done), 32'h8);
        check_eq("t4_err", 32'(err), 32'd1);
        check_eq("t4_no_enable", 32'(bus_enable), 32'd0);
        req = '0;
        step();
        step();

        // Fresh reset so the pointer starts at 0, then all four request continuously.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        for (int i = 0; i < NUM_REQ; i++) set_slot(i, i, i + 4);
        req = '1;
        for (int n = 0; n < 16; n++) begin
            step();
            if (done != 0) got_ord.push_back(idx_of(NUM_REG'(done)));
        end
        req = '0;
        repeat (3) step();
        check_eq("t3_done_count", 32'(got_ord.size() >= 5), 32'd1);
        if (got_ord.size() >= 5) begin
            for (int k = 0; k < 5; k++) check_eq("t3_done_order", 32'(got_ord[k]), 32'(exp_ord[k]));
        end

        // Reset during SETUP aborts the move R0 -> R7.
        saved = regs[7];
        set_slot(2, 0, 7);
        req = 4'b0100;
        step();
        check_eq("t5_setup_enable", 32'(bus_enable), 32'h01);
        #2 reset = 1'b0;
        #1;
        check_eq("t5_enable_drop", 32'(bus_enable), 32'd0);
        check_eq("t5_latch_drop", 32'(bus_latch), 32'd0);
        check_eq("t5_done_none", 32'(done), 32'd0);
        check_eq("t5_busy_drop", 32'(busy), 32'd0);
        req = '0;
        step();
        step();
        reset = 1'b1;
        repeat (3) step();
        check_eq("t5_r7_unchanged", 32'(regs[7]), 32'(saved));

        // A request dropped right after being sampled still completes.
        saved = regs[1];
        set_slot(0, 1, 3);
        req = 4'b0001;
        step();
        req = '0;
        step();
        check_eq("drop_early_done", 32'(done), 32'h1);
        step();
        check_eq("drop_early_r3", 32'(regs[3]), 32'(saved));
        step();

        // Random requesters obeying the handshake.
        active = '0;
        drop   = '0;
        timed  = '0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (drop[i]) begin
                    req[i]    = 1'b0;
                    active[i] = 1'b0;
                    drop[i]   = 1'b0;
                end else if (!active[i] && $urandom_range(3) == 0) begin
                    rs = int'($urandom_range(NUM_REG - 1));
                    rd = ($urandom_range(7) == 0) ? rs : int'($urandom_range(NUM_REG - 1));
                    set_slot(i, rs, rd);
                    req[i]     = 1'b1;
                    active[i]  = 1'b1;
                    timed[i]   = 1'b0;
                    start_c[i] = cycle;
                end
            end
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_now.done[i]) drop[i] = 1'b1;
                if (active[i] && done[i]) begin
                    check_eq("rand_latency", 32'((cycle - start_c[i]) <= BOUND), 32'd1);
                end else if (active[i] && !timed[i] && (cycle - start_c[i]) > BOUND) begin
                    timed[i] = 1'b1;
                    check_eq("rand_timeout", 32'(cycle - start_c[i]), 32'(BOUND));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
